// File: rtl/avmm_pkg.sv
// ---------------------------------------------------------------------------
// avmm_pkg: bus widths and helpers shared by the avmm_rw responder.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package avmm_pkg;

  localparam int AVMM_ADDR_W = 64;
  localparam int AVMM_DATA_W = 64;
  localparam int AVMM_BE_W   = 8;

  function automatic logic [AVMM_DATA_W-1:0] be_merge(
    input logic [AVMM_DATA_W-1:0] old_data,
    input logic [AVMM_DATA_W-1:0] new_data,
    input logic [AVMM_BE_W-1:0]   be
  );
    logic [AVMM_DATA_W-1:0] merged;
    merged = old_data;
    for (int i = 0; i < AVMM_BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_data[8*i +: 8];
    end
    return merged;
  endfunction

  // Subtract before comparing so a window near the top of the space cannot wrap.
  function automatic logic in_window(
    input logic [AVMM_ADDR_W-1:0] addr,
    input logic [AVMM_ADDR_W-1:0] base,
    input logic [AVMM_ADDR_W-1:0] depth_words
  );
    return (addr >= base) && ((addr - base) < (depth_words << 3));
  endfunction

endpackage

`default_nettype wire

// File: rtl/avmm_rd_pipe.sv
// ---------------------------------------------------------------------------
// avmm_rd_pipe: fixed-latency {valid, data} return pipeline; output data holds.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module avmm_rd_pipe
  import avmm_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [AVMM_DATA_W-1:0] in_data,
  output logic                   out_valid,
  output logic [AVMM_DATA_W-1:0] out_data
);

  logic [LATENCY-1:0]     valid_d, valid_q;
  logic [AVMM_DATA_W-1:0] data_d [LATENCY];
  logic [AVMM_DATA_W-1:0] data_q [LATENCY];

  // Stages only load on a valid beat, so the last stage holds the previous read.
  always_comb begin
    valid_d[0] = in_valid;
    data_d[0]  = in_valid ? in_data : data_q[0];
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/avmm_rw_responder.sv
// ---------------------------------------------------------------------------
// avmm_rw_responder: never-stalling Avalon-MM slave memory with fixed read latency.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module avmm_rw_responder
  import avmm_pkg::*;
#(
  parameter int                     DEPTH        = 1024,
  parameter logic [AVMM_ADDR_W-1:0] BASE_ADDR    = 64'h0,
  parameter int                     READ_LATENCY = 1,
  parameter logic [AVMM_DATA_W-1:0] OOR_DATA     = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [AVMM_ADDR_W-1:0] avs_address,
  input  logic [AVMM_BE_W-1:0]   avs_byteenable,
  input  logic                   avs_read,
  input  logic                   avs_write,
  input  logic [AVMM_DATA_W-1:0] avs_writedata,
  output logic [AVMM_DATA_W-1:0] avs_readdata,
  output logic                   avs_readdatavalid,
  output logic [31:0]            rd_count,
  output logic [31:0]            wr_count,
  output logic                   oor_error,
  output logic                   collision_error,
  input  logic                   clear_errors
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [AVMM_DATA_W-1:0] mem_q [DEPTH];

  logic [AVMM_ADDR_W-1:0] offset;
  logic [IDX_W-1:0]       idx;
  logic                   in_range;
  logic                   unused_addr_bits;
  logic                   mem_we;
  logic [AVMM_DATA_W-1:0] mem_wdata;
  logic [AVMM_DATA_W-1:0] rd_data;

  logic [31:0] rd_count_d, rd_count_q;
  logic [31:0] wr_count_d, wr_count_q;
  logic        oor_error_d, oor_error_q;
  logic        collision_error_d, collision_error_q;

  assign offset           = avs_address - BASE_ADDR;
  assign idx              = offset[IDX_W+2:3];
  assign unused_addr_bits = ^{offset[AVMM_ADDR_W-1:IDX_W+3], offset[2:0]};
  assign in_range         = in_window(avs_address, BASE_ADDR, AVMM_ADDR_W'(DEPTH));

  // Read and write share one address, so a colliding read sees the pre-write word.
  always_comb begin
    mem_we    = avs_write && in_range && !reset;
    mem_wdata = be_merge(mem_q[idx], avs_writedata, avs_byteenable);
    rd_data   = in_range ? mem_q[idx] : OOR_DATA;
  end

  // Contents survive reset on purpose.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[idx] <= mem_wdata;
  end

  always_comb begin
    rd_count_d        = rd_count_q;
    wr_count_d        = wr_count_q;
    if (avs_read  && rd_count_q != 32'hFFFF_FFFF) rd_count_d = rd_count_q + 32'd1;
    if (avs_write && wr_count_q != 32'hFFFF_FFFF) wr_count_d = wr_count_q + 32'd1;
    // A new error in the clearing cycle wins over the clear.
    oor_error_d       = (oor_error_q && !clear_errors) ||
                        ((avs_read || avs_write) && !in_range);
    collision_error_d = (collision_error_q && !clear_errors) || (avs_read && avs_write);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_count_q        <= '0;
      wr_count_q        <= '0;
      oor_error_q       <= 1'b0;
      collision_error_q <= 1'b0;
    end else begin
      rd_count_q        <= rd_count_d;
      wr_count_q        <= wr_count_d;
      oor_error_q       <= oor_error_d;
      collision_error_q <= collision_error_d;
    end
  end

  avmm_rd_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (avs_read),
    .in_data   (rd_data),
    .out_valid (avs_readdatavalid),
    .out_data  (avs_readdata)
  );

  assign rd_count        = rd_count_q;
  assign wr_count        = wr_count_q;
  assign oor_error       = oor_error_q;
  assign collision_error = collision_error_q;

endmodule

`default_nettype wire
